// File: rtl/tpg_pkg.sv
// Shared definitions for the AXI-Stream test pattern generator:
// frame FSM state encoding, pattern select codes and a counter-width helper.
package tpg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } tpg_state_t;

  typedef enum logic [1:0] {
    PAT_X_RAMP  = 2'd0,
    PAT_Y_RAMP  = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_XY_SUM  = 2'd3
  } tpg_pattern_t;

  // $clog2 of a count, but never narrower than one bit (a count of 1 still needs a register)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tpg_pattern_lut.sv
// Combinational pixel generator: maps (x, y, pattern) to one pixel value.
// Ramps and the diagonal sum wrap modulo 2^DATA_WIDTH; the checkerboard
// uses 8x8 tiles (bit 3 of each coordinate).
module tpg_pattern_lut
  import tpg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9
) (
  input  logic [X_WIDTH-1:0]    x,
  input  logic [Y_WIDTH-1:0]    y,
  input  logic [1:0]            pattern,
  output logic [DATA_WIDTH-1:0] pixel
);

  logic x_bit3_s;
  logic y_bit3_s;

  // Tile bits; a coordinate narrower than 4 bits always sits in tile 0
  always_comb begin
    x_bit3_s = |(x & X_WIDTH'(4'd8));
    y_bit3_s = |(y & Y_WIDTH'(4'd8));
  end

  // Pattern select
  always_comb begin
    case (tpg_pattern_t'(pattern))
      PAT_X_RAMP:  pixel = DATA_WIDTH'(x);
      PAT_Y_RAMP:  pixel = DATA_WIDTH'(y);
      PAT_CHECKER: begin
        if (x_bit3_s ^ y_bit3_s) begin
          pixel = {DATA_WIDTH{1'b1}};
        end else begin
          pixel = {DATA_WIDTH{1'b0}};
        end
      end
      PAT_XY_SUM:  pixel = DATA_WIDTH'(x) + DATA_WIDTH'(y);
      default:     pixel = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/axis_test_pattern_gen.sv
// AXI-Stream video test pattern generator.
// IDLE -> ACTIVE (one frame of FRAME_WIDTH x FRAME_HEIGHT beats) -> BLANK
// (BLANK_CYCLES idle cycles) -> ACTIVE/IDLE. Frames always complete once
// started; the pattern select is sampled only when a frame starts.
// All stream outputs are registered: the next beat is computed from the
// next coordinates and loaded on the edge that starts/advances the frame.
// Optional feature macro: TPG_FRAME_COUNT_EN enables the 16-bit completed
// frame counter; without it o_frame_count is tied to zero.
module axis_test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int BLANK_CYCLES    = 16
) (
  input  logic                       i_axi_clk,
  input  logic                       i_axi_rst,
  input  logic                       i_enable,
  input  logic [1:0]                 i_pattern,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
  output logic                       o_busy,
  output logic [15:0]                o_frame_count
);

  localparam int XW = cnt_width(FRAME_WIDTH);
  localparam int YW = cnt_width(FRAME_HEIGHT);
  localparam int BW = cnt_width(BLANK_CYCLES);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0] B_LAST = BW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

  tpg_state_t                 state_r;
  logic [XW-1:0]              x_r;
  logic [YW-1:0]              y_r;
  logic [1:0]                 pat_r;
  logic [BW-1:0]              blank_cnt_r;
  logic                       tvalid_r;
  logic                       tuser_r;
  logic                       tlast_r;
  logic [AXIS_DATA_WIDTH-1:0] tdata_r;
  logic                       busy_r;

  logic                       accept_s;
  logic                       frame_end_s;
  logic                       blank_done_s;
  logic                       start_s;
  logic                       load_s;
  logic [XW-1:0]              nx_s;
  logic [YW-1:0]              ny_s;
  logic [1:0]                 npat_s;
  logic [AXIS_DATA_WIDTH-1:0] pix_s;

  // Handshake and frame-boundary events for this cycle
  always_comb begin
    accept_s     = (state_r == ST_ACTIVE) && tvalid_r && i_axis_out_tready;
    frame_end_s  = accept_s && (x_r == X_LAST) && (y_r == Y_LAST);
    blank_done_s = (state_r == ST_BLANK) && (blank_cnt_r == B_LAST);
    // A zero-length blank lets the last pixel's edge start the next frame directly
    start_s      = i_enable && ((state_r == ST_IDLE) || blank_done_s ||
                                (frame_end_s && (BLANK_CYCLES == 0)));
    load_s       = start_s || (accept_s && !frame_end_s);
  end

  // Next raster position and the pattern that applies to it
  always_comb begin
    nx_s   = x_r;
    ny_s   = y_r;
    npat_s = pat_r;
    if (start_s) begin
      nx_s   = {XW{1'b0}};
      ny_s   = {YW{1'b0}};
      npat_s = i_pattern;
    end else if (accept_s) begin
      if (x_r == X_LAST) begin
        nx_s = {XW{1'b0}};
        if (y_r == Y_LAST) begin
          ny_s = {YW{1'b0}};
        end else begin
          ny_s = y_r + YW'(1'b1);
        end
      end else begin
        nx_s = x_r + XW'(1'b1);
        ny_s = y_r;
      end
    end else begin
      nx_s = x_r;
      ny_s = y_r;
    end
  end

  tpg_pattern_lut #(
    .DATA_WIDTH (AXIS_DATA_WIDTH),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW)
  ) u_lut (
    .x       (nx_s),
    .y       (ny_s),
    .pattern (npat_s),
    .pixel   (pix_s)
  );

  // Frame FSM, raster counters and registered stream/status outputs
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      state_r     <= ST_IDLE;
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      pat_r       <= 2'd0;
      blank_cnt_r <= {BW{1'b0}};
      tvalid_r    <= 1'b0;
      tuser_r     <= 1'b0;
      tlast_r     <= 1'b0;
      tdata_r     <= {AXIS_DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      x_r   <= nx_s;
      y_r   <= ny_s;
      pat_r <= npat_s;
      if (load_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= pix_s;
        tuser_r  <= (nx_s == {XW{1'b0}}) && (ny_s == {YW{1'b0}});
        tlast_r  <= (nx_s == X_LAST);
      end else if ((state_r != ST_ACTIVE) || frame_end_s) begin
        tvalid_r <= 1'b0;
        tdata_r  <= {AXIS_DATA_WIDTH{1'b0}};
        tuser_r  <= 1'b0;
        tlast_r  <= 1'b0;
      end else begin
        // Stalled beat: hold everything until the sink takes it
        tvalid_r <= tvalid_r;
      end
      case (state_r)
        ST_IDLE: begin
          blank_cnt_r <= {BW{1'b0}};
          if (start_s) begin
            state_r <= ST_ACTIVE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          blank_cnt_r <= {BW{1'b0}};
          if (frame_end_s) begin
            if (start_s) begin
              state_r <= ST_ACTIVE;
              busy_r  <= 1'b1;
            end else if (BLANK_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_BLANK;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_ACTIVE;
            busy_r  <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (blank_done_s) begin
            blank_cnt_r <= {BW{1'b0}};
            if (start_s) begin
              state_r <= ST_ACTIVE;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            blank_cnt_r <= blank_cnt_r + BW'(1'b1);
            state_r     <= ST_BLANK;
            busy_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          blank_cnt_r <= {BW{1'b0}};
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef TPG_FRAME_COUNT_EN
  logic [15:0] frame_count_r;

  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      frame_count_r <= 16'd0;
    end else if (frame_end_s) begin
      frame_count_r <= frame_count_r + 16'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  assign o_frame_count = frame_count_r;
`else
  assign o_frame_count = 16'd0;
`endif

  assign o_axis_out_tvalid = tvalid_r;
  assign o_axis_out_tuser  = tuser_r;
  assign o_axis_out_tlast  = tlast_r;
  assign o_axis_out_tdata  = tdata_r;
  assign o_busy            = busy_r;

endmodule
